conv_window_scheduler: RTL and testbench

Control block for the 7x7 IFM / 3x3 kernel convolution datapath. It sequences frame loading of the IFM and weight buffers and then issues the 25 sliding-window positions to the multiply/add pipeline. It also tracks each issued window through the pipeline latency, so it can mark result validity, the last result and frame completion. It sits between the stream source and the convolution datapath, replacing free-running count-based sequencing.

---
 rtl/conv_pkg.sv | 29 ++
 rtl/conv_tag_pipe.sv | 47 ++++
 rtl/conv_window_scheduler.sv | 161 ++++++++++++++++
 tb/tb_conv_window_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants, state encoding and window-index helper for the
// 7x7 IFM / 3x3 kernel convolution window scheduler.
package conv_pkg;

  localparam int IFM_DIM      = 7;
  localparam int K_DIM        = 3;
  localparam int OUT_DIM      = IFM_DIM - K_DIM + 1;
  localparam int NUM_WIN      = OUT_DIM * OUT_DIM;
  localparam int PIPE_LAT_DEF = 3;

  // Counter limits and special window positions, sized to the hardware counters
  localparam logic [5:0] IFM_FULL  = 6'(IFM_DIM * IFM_DIM);
  localparam logic [3:0] W_FULL    = 4'(K_DIM * K_DIM);
  localparam logic [2:0] POS_MAX   = 3'(OUT_DIM - 1);
  localparam logic [5:0] LAST_BASE = 6'((OUT_DIM - 1) * IFM_DIM + (OUT_DIM - 1));

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } sched_state_e;

  // Top-left buffer index of the window at output position (row, col)
  function automatic logic [5:0] win_index(input logic [2:0] row, input logic [2:0] col);
    return (6'(row) * 6'(IFM_DIM)) + 6'(col);
  endfunction

endpackage

// File: rtl/conv_tag_pipe.sv
// {valid,last} delay line that follows each issued window through the
// datapath latency. inflight reports whether any tag still has to reach
// the output stage after the current edge.
module conv_tag_pipe #(
  parameter int LAT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tag_valid,
  input  logic tag_last,
  output logic out_valid,
  output logic out_last,
  output logic inflight
);

  logic [LAT-1:0] vld_r;
  logic [LAT-1:0] lst_r;
  logic           inflight_s;

  // Shift tags one stage per cycle; stage 0 captures the new window tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= '0;
      lst_r <= '0;
    end else begin
      vld_r[0] <= tag_valid;
      lst_r[0] <= tag_last;
      for (int i = 1; i < LAT; i++) begin
        vld_r[i] <= vld_r[i-1];
        lst_r[i] <= lst_r[i-1];
      end
    end
  end

  // Any valid tag in a stage other than the output stage is still in flight
  always_comb begin
    inflight_s = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      inflight_s = inflight_s | vld_r[i];
    end
  end

  assign out_valid = vld_r[LAT-1];
  assign out_last  = lst_r[LAT-1];
  assign inflight  = inflight_s;

endmodule

// File: rtl/conv_window_scheduler.sv
// Frame sequencer for the convolution datapath: loads IFM and weight
// buffers, issues the 25 sliding-window positions under sched_ready
// back-pressure, and tracks results through the pipeline to flag the
// last result and frame completion.
module conv_window_scheduler
  import conv_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       weight_valid,
  input  logic       sched_ready,
  output logic       ifm_we,
  output logic [5:0] ifm_addr,
  output logic       w_we,
  output logic [3:0] w_addr,
  output logic       win_valid,
  output logic [5:0] win_base,
  output logic       out_valid,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic       err_busy
);

  sched_state_e state_r, state_s;
  logic [5:0]   ifm_cnt_r;
  logic [3:0]   w_cnt_r;
  logic [2:0]   row_r, col_r;
  logic         load_phase_s;
  logic         issue_s;
  logic         drain_exit_s;
  logic         inflight_s;
  logic         tag_last_s;

  assign load_phase_s = (state_r == ST_IDLE) || (state_r == ST_LOAD);
  assign ifm_we       = in_valid && load_phase_s && (ifm_cnt_r < IFM_FULL);
  assign w_we         = weight_valid && load_phase_s && (w_cnt_r < W_FULL);
  assign ifm_addr     = ifm_cnt_r;
  assign w_addr       = w_cnt_r;
  assign drain_exit_s = (state_r == ST_DRAIN) && (state_s == ST_IDLE);
  assign tag_last_s   = win_valid && (win_base == LAST_BASE);

  // Next-state and issue decision
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ifm_we || w_we) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (((ifm_cnt_r + {5'd0, ifm_we}) == IFM_FULL) &&
            ((w_cnt_r + {3'd0, w_we}) == W_FULL)) begin
          state_s = ST_COMPUTE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_COMPUTE: begin
        if (sched_ready) begin
          issue_s = 1'b1;
          if ((row_r == POS_MAX) && (col_r == POS_MAX)) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_COMPUTE;
          end
        end else begin
          state_s = ST_COMPUTE;
        end
      end
      ST_DRAIN: begin
        if (!win_valid && !inflight_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Load counters and window row/col position; all cleared when the frame drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifm_cnt_r <= 6'd0;
      w_cnt_r   <= 4'd0;
      row_r     <= 3'd0;
      col_r     <= 3'd0;
    end else if (drain_exit_s) begin
      ifm_cnt_r <= 6'd0;
      w_cnt_r   <= 4'd0;
      row_r     <= 3'd0;
      col_r     <= 3'd0;
    end else begin
      if (ifm_we) begin
        ifm_cnt_r <= ifm_cnt_r + 6'd1;
      end
      if (w_we) begin
        w_cnt_r <= w_cnt_r + 4'd1;
      end
      if (issue_s) begin
        if (col_r == POS_MAX) begin
          col_r <= 3'd0;
          row_r <= row_r + 3'd1;
        end else begin
          col_r <= col_r + 3'd1;
        end
      end
    end
  end

  // Registered window issue, status and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid <= 1'b0;
      win_base  <= 6'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_busy  <= 1'b0;
    end else begin
      win_valid <= issue_s;
      if (issue_s) begin
        win_base <= win_index(row_r, col_r);
      end
      busy     <= (state_s != ST_IDLE);
      done     <= drain_exit_s;
      err_busy <= (in_valid || weight_valid) && !load_phase_s;
    end
  end

  conv_tag_pipe #(
    .LAT (PIPE_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .tag_valid (win_valid),
    .tag_last  (tag_last_s),
    .out_valid (out_valid),
    .out_last  (out_last),
    .inflight  (inflight_s)
  );

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Self-checking bench: two schedulers (PIPE_LAT 3 and 5) driven by the same
// stimulus, each compared every cycle against a frame-level reference model.
module tb_conv_window_scheduler;

  logic clk, rst_n, in_valid, weight_valid, sched_ready;
  logic       ifm_we_v [2];
  logic [5:0] ifm_addr_v [2];
  logic       w_we_v [2];
  logic [3:0] w_addr_v [2];
  logic       win_valid_v [2];
  logic [5:0] win_base_v [2];
  logic       out_valid_v [2];
  logic       out_last_v [2];
  logic       busy_v [2];
  logic       done_v [2];
  logic       err_busy_v [2];

  conv_window_scheduler #(.PIPE_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .weight_valid(weight_valid),
    .sched_ready(sched_ready), .ifm_we(ifm_we_v[0]), .ifm_addr(ifm_addr_v[0]),
    .w_we(w_we_v[0]), .w_addr(w_addr_v[0]), .win_valid(win_valid_v[0]),
    .win_base(win_base_v[0]), .out_valid(out_valid_v[0]), .out_last(out_last_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .err_busy(err_busy_v[0]));

  conv_window_scheduler #(.PIPE_LAT(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .weight_valid(weight_valid),
    .sched_ready(sched_ready), .ifm_we(ifm_we_v[1]), .ifm_addr(ifm_addr_v[1]),
    .w_we(w_we_v[1]), .w_addr(w_addr_v[1]), .win_valid(win_valid_v[1]),
    .win_base(win_base_v[1]), .out_valid(out_valid_v[1]), .out_last(out_last_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .err_busy(err_busy_v[1]));

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 load, 2 compute, 3 drain.
  // hv/hl hold win_valid / last-window history, bit 0 = previous cycle.
  typedef struct {
    int        phase, ni, nw, k, wb, lat;
    bit        wv, done, err;
    bit [15:0] hv, hl;
  } m_t;

  typedef struct {
    bit iv, wtv;
    bit e_ifm_we; int e_ifm_addr; bit e_w_we; int e_w_addr; bit e_busy;
  } vec_t;

  m_t mdl [2];
  int nvec = 0, nerr = 0, fc = 0;
  int wv_cnt, first_wv, last_wv, iwe_cnt;
  int ov_cnt [2], ol_cnt [2], done_cnt [2], err_cnt [2], first_ov [2], last_ov [2], done_t [2];

  function automatic m_t mreset(input int lat);
    m_t m;
    m.phase = 0; m.ni = 0; m.nw = 0; m.k = 0; m.wb = 0; m.lat = lat;
    m.wv = 0; m.done = 0; m.err = 0; m.hv = '0; m.hl = '0;
    return m;
  endfunction

  function automatic m_t step(input m_t m, input bit iv, input bit wtv, input bit rdy);
    m_t n;
    bit iw, ww, pend;
    n  = m;
    iw = iv  && (m.phase <= 1) && (m.ni < 49);
    ww = wtv && (m.phase <= 1) && (m.nw < 9);
    n.err  = (iv || wtv) && (m.phase >= 2);
    n.done = 0;
    n.wv   = 0;
    n.hv   = {m.hv[14:0], m.wv};
    n.hl   = {m.hl[14:0], m.wv && (m.wb == 32)};
    n.ni   = m.ni + int'(iw);
    n.nw   = m.nw + int'(ww);
    case (m.phase)
      0: if (iw || ww) n.phase = 1;
      1: if (n.ni == 49 && n.nw == 9) n.phase = 2;
      2: if (rdy) begin
        n.wv = 1;
        n.wb = (m.k / 5) * 7 + (m.k % 5);
        n.k  = m.k + 1;
        if (n.k == 25) n.phase = 3;
      end
      3: begin
        pend = m.wv;
        for (int i = 0; i < m.lat - 1; i++) pend = pend | m.hv[i];
        if (!pend) begin
          n.phase = 0; n.ni = 0; n.nw = 0; n.k = 0; n.done = 1;
        end
      end
      default: n.phase = 0;
    endcase
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_comb(input int i);
    chk($sformatf("ifm_we[%0d]", i), 32'(ifm_we_v[i]),
        32'(in_valid && mdl[i].phase <= 1 && mdl[i].ni < 49));
    chk($sformatf("ifm_addr[%0d]", i), 32'(ifm_addr_v[i]), mdl[i].ni);
    chk($sformatf("w_we[%0d]", i), 32'(w_we_v[i]),
        32'(weight_valid && mdl[i].phase <= 1 && mdl[i].nw < 9));
    chk($sformatf("w_addr[%0d]", i), 32'(w_addr_v[i]), mdl[i].nw);
  endtask

  task automatic chk_regs(input int i);
    chk($sformatf("win_valid[%0d]", i), 32'(win_valid_v[i]), 32'(mdl[i].wv));
    if (mdl[i].wv) chk($sformatf("win_base[%0d]", i), 32'(win_base_v[i]), mdl[i].wb);
    chk($sformatf("out_valid[%0d]", i), 32'(out_valid_v[i]), 32'(mdl[i].hv[mdl[i].lat-1]));
    chk($sformatf("out_last[%0d]", i), 32'(out_last_v[i]), 32'(mdl[i].hl[mdl[i].lat-1]));
    chk($sformatf("busy[%0d]", i), 32'(busy_v[i]), 32'(mdl[i].phase != 0));
    chk($sformatf("done[%0d]", i), 32'(done_v[i]), 32'(mdl[i].done));
    chk($sformatf("err_busy[%0d]", i), 32'(err_busy_v[i]), 32'(mdl[i].err));
  endtask

  task automatic clear_stats();
    wv_cnt = 0; first_wv = -1; last_wv = -1; iwe_cnt = 0; fc = 0;
    for (int i = 0; i < 2; i++) begin
      ov_cnt[i] = 0; ol_cnt[i] = 0; done_cnt[i] = 0; err_cnt[i] = 0;
      first_ov[i] = -1; last_ov[i] = -1; done_t[i] = -1;
    end
  endtask

  // One clock: drive at negedge, check strobes, advance model, check registers after posedge
  task automatic cyc(input bit iv, input bit wtv, input bit rdy);
    in_valid = iv; weight_valid = wtv; sched_ready = rdy;
    #1;
    for (int i = 0; i < 2; i++) chk_comb(i);
    if (ifm_we_v[0]) iwe_cnt++;
    for (int i = 0; i < 2; i++) mdl[i] = step(mdl[i], iv, wtv, rdy);
    @(posedge clk); #1;
    fc++;
    for (int i = 0; i < 2; i++) chk_regs(i);
    if (win_valid_v[0]) begin
      wv_cnt++;
      if (first_wv < 0) first_wv = fc;
      last_wv = fc;
    end
    for (int i = 0; i < 2; i++) begin
      if (out_valid_v[i]) begin
        ov_cnt[i]++;
        if (first_ov[i] < 0) first_ov[i] = fc;
        last_ov[i] = fc;
      end
      if (out_last_v[i]) ol_cnt[i]++;
      if (done_v[i]) begin done_cnt[i]++; done_t[i] = fc; end
      if (err_busy_v[i]) err_cnt[i]++;
    end
    @(negedge clk);
  endtask

  // mode 0: random load densities; 1: every cycle both valids; 2: 52 IFM words, weights late.
  // pr: sched_ready percentage, negative = toggle every cycle. err_at: compute cycle of a stray in_valid.
  task automatic frame(input int mode, input int pr, input int err_at);
    int t, ct, pi, pw;
    bit iv, wtv, rdy;
    t = 0; ct = 0;
    pi = $urandom_range(20, 90);
    pw = $urandom_range(10, 90);
    while (mdl[0].phase < 2 && t < 3000) begin
      case (mode)
        1: begin iv = 1; wtv = 1; end
        2: begin iv = (t < 52); wtv = (t >= 55 && t < 64); end
        default: begin iv = ($urandom_range(99) < pi); wtv = ($urandom_range(99) < pw); end
      endcase
      cyc(iv, wtv, 1'b1);
      t++;
    end
    chk("load_timeout", 32'(t < 3000), 32'd1);
    while ((mdl[0].phase != 0 || mdl[1].phase != 0) && ct < 3000) begin
      rdy = (pr < 0) ? ((fc % 2) == 0) : ($urandom_range(99) < pr);
      cyc(ct == err_at, 1'b0, rdy);
      ct++;
    end
    chk("drain_timeout", 32'(ct < 3000), 32'd1);
    chk("win_count", wv_cnt, 32'd25);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("out_count[%0d]", i), ov_cnt[i], 32'd25);
      chk($sformatf("last_count[%0d]", i), ol_cnt[i], 32'd1);
      chk($sformatf("done_count[%0d]", i), done_cnt[i], 32'd1);
      chk($sformatf("err_count[%0d]", i), err_cnt[i], 32'(err_at >= 0));
      chk($sformatf("out_lag[%0d]", i), first_ov[i] - first_wv, mdl[i].lat);
      chk($sformatf("done_lag[%0d]", i), done_t[i] - last_ov[i], 32'd1);
    end
  endtask

  vec_t tbl [4];

  initial begin
    tbl[0] = '{iv:1, wtv:1, e_ifm_we:1, e_ifm_addr:0, e_w_we:1, e_w_addr:0, e_busy:1};
    tbl[1] = '{iv:1, wtv:0, e_ifm_we:1, e_ifm_addr:1, e_w_we:0, e_w_addr:1, e_busy:1};
    tbl[2] = '{iv:0, wtv:1, e_ifm_we:0, e_ifm_addr:2, e_w_we:1, e_w_addr:1, e_busy:1};
    tbl[3] = '{iv:1, wtv:1, e_ifm_we:1, e_ifm_addr:2, e_w_we:1, e_w_addr:2, e_busy:1};

    clk = 0; rst_n = 0; in_valid = 0; weight_valid = 0; sched_ready = 0;
    mdl[0] = mreset(3); mdl[1] = mreset(5);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk_comb(i); chk_regs(i);
      chk($sformatf("rst_win_base[%0d]", i), 32'(win_base_v[i]), 32'd0);
    end
    rst_n = 1;
    @(negedge clk);

    // Table-driven start of a frame, then finish it at full rate
    clear_stats();
    for (int v = 0; v < 4; v++) begin
      in_valid = tbl[v].iv; weight_valid = tbl[v].wtv; sched_ready = 1'b1;
      #1;
      chk($sformatf("tbl%0d_ifm_we", v), 32'(ifm_we_v[0]), 32'(tbl[v].e_ifm_we));
      chk($sformatf("tbl%0d_ifm_addr", v), 32'(ifm_addr_v[0]), tbl[v].e_ifm_addr);
      chk($sformatf("tbl%0d_w_we", v), 32'(w_we_v[0]), 32'(tbl[v].e_w_we));
      chk($sformatf("tbl%0d_w_addr", v), 32'(w_addr_v[0]), tbl[v].e_w_addr);
      cyc(tbl[v].iv, tbl[v].wtv, 1'b1);
      chk($sformatf("tbl%0d_busy", v), 32'(busy_v[0]), 32'(tbl[v].e_busy));
    end
    frame(1, 100, -1);

    // Minimum-length frame: exact first issue and done cycles
    clear_stats();
    frame(1, 100, -1);
    chk("min_first_win", first_wv, 32'd50);
    chk("min_done3", done_t[0], 32'd78);
    chk("min_done5", done_t[1], 32'd80);

    // 52 IFM words, weights after the IFM, stray in_valid during COMPUTE
    clear_stats();
    frame(2, 100, 5);
    chk("ifm_writes", iwe_cnt, 32'd49);
    chk("late_w_first_win", first_wv, 32'd65);

    // sched_ready toggling every cycle
    clear_stats();
    frame(1, -1, -1);
    chk("toggle_span", last_wv - first_wv + 1, 32'd49);

    // Reset at window 10, then a clean frame
    clear_stats();
    for (int t = 0; t < 200 && mdl[0].phase < 2; t++) cyc(1'b1, 1'b1, 1'b1);
    for (int t = 0; t < 200 && mdl[0].k < 10; t++) cyc(1'b0, 1'b0, 1'b1);
    chk("pre_reset_k", mdl[0].k, 32'd10);
    rst_n = 0;
    in_valid = 0; weight_valid = 0; sched_ready = 1;
    mdl[0] = mreset(3); mdl[1] = mreset(5);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk_comb(i); chk_regs(i);
      chk($sformatf("midrst_win_base[%0d]", i), 32'(win_base_v[i]), 32'd0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) chk_regs(i);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    clear_stats();
    frame(1, 100, -1);

    // Randomised frames
    for (int r = 0; r < 6; r++) begin
      clear_stats();
      frame(0, $urandom_range(30, 100), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
